// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter giving a CPU port and a loader/debug port shared
// access to a single-ported data memory; one access per 3 cycles.
module data_mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        grant;
  logic        err;

  // Misaligned or beyond the memory's word range
  assign err = (addr_q[1:0] != 2'b00) ||
               (addr_q[31:ADDR_W+2] != '0);

  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = wdata_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign p0_err    = p0_ack & err;
  assign p1_err    = p1_ack & err;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mem_we   = 1'b0;
    p0_ack   = 1'b0;
    p1_ack   = 1'b0;
    // ptr_q names the port that wins a tie
    grant    = (p0_req && p1_req) ? ptr_q : p1_req;
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          win_d   = grant;
          ptr_d   = ~grant;
          we_d    = grant ? p1_we : p0_we;
          addr_d  = grant ? p1_addr : p0_addr;
          wdata_d = grant ? p1_wdata : p0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_we = we_q & ~err;
        if (!we_q && !err) begin
          if (win_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        p0_ack  = ~win_q;
        p1_ack  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Random two-port traffic against a transaction-level model of the
// arbiter plus a directed reset-abort scenario.
module tb_data_mem_arbiter;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        preq[2];
  logic        pwe[2];
  logic [31:0] paddr[2];
  logic [31:0] pwdata[2];
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] dut_mem[1024];

  always #5 clk = ~clk;

  assign mem_rdata = dut_mem[mem_addr];
  always @(posedge clk) if (mem_we) dut_mem[mem_addr] <= mem_wdata;

  data_mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(preq[0]), .p0_we(pwe[0]),
    .p0_addr(paddr[0]), .p0_wdata(pwdata[0]),
    .p1_req(preq[1]), .p1_we(pwe[1]),
    .p1_addr(paddr[1]), .p1_wdata(pwdata[1]),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: ph 0 = free, 1 = memory cycle, 2 = response cycle
  int          ph;
  int          last;
  int          w;
  int          n_acks;
  bit          both_mode;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] ref_mem[1024];
  logic [31:0] ref_rd[2];

  function automatic bit bad_addr(logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 15) * 4;
    if (r == 7) return $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
    if (r == 8) return 32'h1000 + $urandom_range(0, 63) * 4;
    return $urandom;
  endfunction

  task automatic new_req(int p);
    preq[p]   = 1'b1;
    pwe[p]    = 1'($urandom_range(0, 1));
    paddr[p]  = rnd_addr();
    pwdata[p] = $urandom;
  endtask

  task automatic model_init();
    ph = 0;
    last = 1;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
  endtask

  task automatic step();
    bit bad;
    @(negedge clk);
    bad = bad_addr(m_addr);
    check("both_ack", 32'(p0_ack & p1_ack), 0);
    case (ph)
      0: begin
        check("idle_ack0", 32'(p0_ack), 0);
        check("idle_ack1", 32'(p1_ack), 0);
        check("idle_we", 32'(mem_we), 0);
      end
      1: begin
        check("acc_ack", 32'(p0_ack | p1_ack), 0);
        check("acc_we", 32'(mem_we), 32'(m_we && !bad));
        check("acc_addr", 32'(mem_addr), 32'(m_addr[11:2]));
        check("acc_wdata", mem_wdata, m_wdata);
        if (!bad) begin
          if (m_we) ref_mem[m_addr[11:2]] = m_wdata;
          else ref_rd[w] = ref_mem[m_addr[11:2]];
        end
      end
      default: begin
        n_acks++;
        check("resp_ack0", 32'(p0_ack), 32'(w == 0));
        check("resp_ack1", 32'(p1_ack), 32'(w == 1));
        check("resp_err", 32'(w ? p1_err : p0_err), 32'(bad));
        check("resp_err_other", 32'(w ? p0_err : p1_err), 0);
        check("resp_we", 32'(mem_we), 0);
        check("rdata0", p0_rdata, ref_rd[0]);
        check("rdata1", p1_rdata, ref_rd[1]);
      end
    endcase
    if (ph == 2) begin
      if (both_mode || $urandom_range(0, 1) == 1) new_req(w);
      else preq[w] = 1'b0;
    end
    for (int p = 0; p < 2; p++)
      if (!preq[p] && (both_mode || $urandom_range(0, 2) == 0))
        new_req(p);
    if (ph == 1) ph = 2;
    else if (ph == 2) ph = 0;
    else if (preq[0] || preq[1]) begin
      if (preq[0] && preq[1]) w = 1 - last;
      else w = preq[1] ? 1 : 0;
      last    = w;
      m_we    = pwe[w];
      m_addr  = paddr[w];
      m_wdata = pwdata[w];
      ph      = 1;
    end
  endtask

  task automatic hard_reset();
    reset   = 1'b1;
    preq[0] = 1'b0;
    preq[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  task automatic reset_abort();
    reset   = 1'b1;
    preq[0] = 1'b0;
    preq[1] = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    preq[0]   = 1'b1;
    pwe[0]    = 1'b1;
    paddr[0]  = 32'h8;
    pwdata[0] = 32'd9;
    @(negedge clk);
    check("abort_acc_we", 32'(mem_we), 1);
    check("abort_acc_addr", 32'(mem_addr), 2);
    reset = 1'b1;
    #1;
    check("abort_we_off", 32'(mem_we), 0);
    check("abort_no_ack", 32'(p0_ack), 0);
    preq[0] = 1'b0;
    @(negedge clk);
    check("abort_no_ack2", 32'(p0_ack), 0);
    check("abort_mem2", dut_mem[2], ref_mem[2]);
    @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dut_mem[i] = $urandom;
      ref_mem[i] = dut_mem[i];
    end
    dut_mem[2] = 32'hdead_0002;
    ref_mem[2] = 32'hdead_0002;
    preq[0] = 1'b0; pwe[0] = 1'b0; paddr[0] = '0; pwdata[0] = '0;
    preq[1] = 1'b0; pwe[1] = 1'b0; paddr[1] = '0; pwdata[1] = '0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    w = 0;
    n_acks = 0;
    both_mode = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_ack0", 32'(p0_ack), 0);
    check("rst_ack1", 32'(p1_ack), 0);
    check("rst_err", 32'(p0_err | p1_err), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata0", p0_rdata, 0);
    check("rst_rdata1", p1_rdata, 0);
    hard_reset();
    both_mode = 1'b1;
    for (int i = 0; i < 40; i++) step();
    both_mode = 1'b0;
    for (int i = 0; i < 600; i++) step();
    reset_abort();
    both_mode = 1'b1;
    for (int i = 0; i < 12; i++) step();
    both_mode = 1'b0;
    for (int i = 0; i < 600; i++) step();
    check("acks_seen", 32'(n_acks > 100), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, word-index width of the shared data memory (1024 words).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 p0_req / p1_req  input  1 each  access request; port 0 = CPU, port 1 = loader/debug.
REQ-005 p0_we / p1_we  input  1 each  1 = write, 0 = read.
REQ-006 p0_addr / p1_addr  input  32 each  byte address.
REQ-007 p0_wdata / p1_wdata  input  32 each  write data.
REQ-008 p0_ack / p1_ack  output  1 each  one-cycle completion pulse.
REQ-009 p0_err / p1_err  output  1 each  valid only with the matching ack; 1 = access rejected.
REQ-010 p0_rdata / p1_rdata  output  32 each  read data, held from ack until that port's next ack.
REQ-011 mem_we  output  1  write enable to the data memory (memory writes on rising clk).
REQ-012 mem_addr  output  ADDR_W  word index = byte address bits [ADDR_W+1:2].
REQ-013 mem_wdata  output  32  write data to memory.
REQ-014 mem_rdata  input  32  combinational read data for the current mem_addr.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; encoding is free.
REQ-016 IDLE: when any req=1, select a winner, latch its we/addr/wdata, go to ACCESS; otherwise stay in IDLE.
REQ-017 Arbitration is round-robin; when both ports request, the port not granted last wins; the pointer updates only on a grant.
REQ-018 Only one port requesting: that port wins regardless of the pointer.
REQ-019 ACCESS lasts exactly 1 cycle and drives mem_addr and mem_wdata from the latched request.
REQ-020 In ACCESS, mem_we = latched we AND NOT err; mem_rdata is captured into the winner's rdata register at the end of ACCESS for reads only.
REQ-021 err = 1 when latched addr[1:0] != 0 or addr[31:ADDR_W+2] != 0; an errored read leaves rdata unchanged; an errored write performs no memory write.
REQ-022 RESP: assert the winner's ack (and err) for exactly 1 cycle, then return to IDLE.
REQ-023 Latency: req sampled in IDLE at edge N gives ack high during cycle N+2; port throughput is 1 access per 3 cycles.
REQ-024 Requesters hold req/we/addr/wdata stable until ack; inputs are sampled only in IDLE, so changes in ACCESS/RESP have no effect on the transaction in flight.
REQ-025 Req still high in the cycle after ack counts as a new request.
REQ-026 Starvation bound: with both ports continuously requesting, each port is granted at least once every 2 transactions (6 cycles).
REQ-027 Outside ACCESS: mem_we = 0, while mem_addr and mem_wdata hold their last values.
REQ-028 ack is never asserted for a port that did not win, and both acks are never high in the same cycle.

Reset
REQ-029 On reset assertion, immediately: state = IDLE, mem_we = 0, both acks = 0, both errs = 0, round-robin pointer = port 0 next.
REQ-030 On reset: both rdata registers = 0, mem_addr = 0, mem_wdata = 0.
REQ-031 Reset during ACCESS or RESP aborts the transaction with no ack; if reset is asserted before the ACCESS rising edge, no memory write occurs.
REQ-032 The first arbitration after reset release grants port 0 when both ports request.

Verification
REQ-033 p0 write addr 0x4, data 7, then p0 read 0x4 -> mem_we pulses 1 cycle with mem_addr=1 and mem_wdata=7; the read ack returns p0_rdata=7 with err=0.
REQ-034 p0 and p1 both continuously request after reset -> ack order p0, p1, p0, p1 with acks 3 cycles apart.
REQ-035 p1 write addr 0x6 (misaligned), then p1 write addr 0x1000 (out of range) -> each gets p1_ack with p1_err=1 and mem_we stays 0.
REQ-036 Reset asserted in the ACCESS cycle of a p0 write of 9 to 0x8 -> no p0_ack, memory word 2 unchanged, FSM in IDLE.
REQ-037 p1 alone requests 3 back-to-back reads of 0x0, 0x4, 0x8 with memory holding 1, 2, 3 -> p1_rdata = 1, 2, 3 on acks at cycles N+2, N+5, N+8.
